// File: rtl/gpr_wb_arb_pkg.sv
// Shared types and constants for the GPR write-port arbiter and its B-side FIFO.
// Addresses and data match the 32 x 32-bit register file.
package gpr_wb_arb_pkg;

   localparam int GPR_NUM    = 32;
   localparam int GPR_ADDR_W = 5;
   localparam int GPR_DATA_W = 32;

   // Write enables are active-low throughout the register file path
   localparam logic WE_ACTIVE = 1'b0;
   localparam logic WE_IDLE   = 1'b1;

   typedef logic [GPR_ADDR_W-1:0] reg_addr_t;
   typedef logic [GPR_DATA_W-1:0] word_t;

   typedef struct packed {
      reg_addr_t addr;
      word_t     data;
   } wb_entry_t;

endpackage

// File: rtl/gpr_wb_arb_if.sv
// Bundle of every signal between the arbiter and its neighbours.
// The arbiter takes the slave view; WB, issue, decode and the register file take the master view.
interface gpr_wb_arb_if;
   import gpr_wb_arb_pkg::*;

   logic      a_we_;
   reg_addr_t a_addr;
   word_t     a_data;
   logic      b_req;
   reg_addr_t b_addr;
   word_t     b_data;
   logic      b_ack;
   logic      sb_set;
   reg_addr_t sb_set_addr;
   reg_addr_t chk_addr_0;
   reg_addr_t chk_addr_1;
   reg_addr_t chk_addr_d;
   logic      busy_0;
   logic      busy_1;
   logic      busy_d;
   logic      stall_req;
   logic      gpr_we_;
   reg_addr_t gpr_wr_addr;
   word_t     gpr_wr_data;

   modport slave (
      input  a_we_, a_addr, a_data, b_req, b_addr, b_data,
             sb_set, sb_set_addr, chk_addr_0, chk_addr_1, chk_addr_d,
      output b_ack, busy_0, busy_1, busy_d, stall_req,
             gpr_we_, gpr_wr_addr, gpr_wr_data
   );

   modport master (
      output a_we_, a_addr, a_data, b_req, b_addr, b_data,
             sb_set, sb_set_addr, chk_addr_0, chk_addr_1, chk_addr_d,
      input  b_ack, busy_0, busy_1, busy_d, stall_req,
             gpr_we_, gpr_wr_addr, gpr_wr_data
   );

endinterface

// File: rtl/gpr_wb_fifo.sv
// Small synchronous FIFO buffering long-latency writebacks until the write port is free.
// Full/empty come from an explicit count so the pointers can wrap naturally.
module gpr_wb_fifo
   import gpr_wb_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  wb_entry_t push_entry,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output wb_entry_t head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage carries no reset; contents are only meaningful below count
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/gpr_wb_arb.sv
// Shares the single GPR write port between WB (never stalled) and a buffered long-latency unit,
// and keeps the busy scoreboard that decode uses to stall on pending long-latency writes.
module gpr_wb_arb
   import gpr_wb_arb_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4,
   parameter int REG_NUM    = GPR_NUM
) (
   input logic          clk,
   input logic          reset,
   gpr_wb_arb_if.slave  bus
);

   localparam int STV_W = $clog2(STARVE_MAX) + 1;

   logic               a_active;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;
   wb_entry_t          head;
   wb_entry_t          push_entry;
   logic [STV_W-1:0]   starve_cnt;
   logic               stall_q;
   logic [REG_NUM-1:0] busy;
   logic [REG_NUM-1:0] busy_nxt;

   assign a_active   = (bus.a_we_ == WE_ACTIVE);
   assign fifo_pop   = !a_active && !fifo_empty;
   assign push_entry = '{addr: bus.b_addr, data: bus.b_data};
   assign bus.b_ack  = bus.b_req && !fifo_full;

   gpr_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (bus.b_req),
      .push_entry (push_entry),
      .pop        (fifo_pop),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head       (head)
   );

   // A always wins the port so WB needs no back-pressure path
   always_comb begin
      bus.gpr_we_     = WE_IDLE;
      bus.gpr_wr_addr = '0;
      bus.gpr_wr_data = '0;
      if (a_active) begin
         bus.gpr_we_     = WE_ACTIVE;
         bus.gpr_wr_addr = bus.a_addr;
         bus.gpr_wr_data = bus.a_data;
      end else if (!fifo_empty) begin
         bus.gpr_we_     = WE_ACTIVE;
         bus.gpr_wr_addr = head.addr;
         bus.gpr_wr_data = head.data;
      end
   end

   // Counter saturates at the threshold; stall_req holds until the FIFO finally drains one entry
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
         stall_q    <= 1'b0;
      end else if (fifo_pop || fifo_empty) begin
         starve_cnt <= '0;
         if (fifo_pop) stall_q <= 1'b0;
      end else if (a_active) begin
         if (starve_cnt == STV_W'(STARVE_MAX - 1)) stall_q <= 1'b1;
         else starve_cnt <= starve_cnt + STV_W'(1);
      end
   end

   assign bus.stall_req = stall_q;

   // A set on the same edge as a retiring commit wins: the new operation owns the register
   always_comb begin
      busy_nxt = busy;
      for (int r = 0; r < REG_NUM; r++) begin
         if (fifo_pop && head.addr == reg_addr_t'(r)) busy_nxt[r] = 1'b0;
         if (bus.sb_set && bus.sb_set_addr == reg_addr_t'(r)) busy_nxt[r] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) busy <= '0;
      else        busy <= busy_nxt;
   end

   assign bus.busy_0 = busy[bus.chk_addr_0];
   assign bus.busy_1 = busy[bus.chk_addr_1];
   assign bus.busy_d = busy[bus.chk_addr_d];

   a_during_stall: assert property (@(posedge clk) disable iff (!reset)
      stall_q |-> !a_active);

   set_on_busy: assert property (@(posedge clk) disable iff (!reset)
      bus.sb_set |-> (!busy[bus.sb_set_addr] || (fifo_pop && head.addr == bus.sb_set_addr)));

endmodule

// File: tb/tb_gpr_wb_arb.sv
// Directed bench for gpr_wb_arb: each phase drives a short hand-worked sequence
// and compares port values against expectations written out by hand.
module tb_gpr_wb_arb;
   import gpr_wb_arb_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   gpr_wb_arb_if bus();

   gpr_wb_arb #(.FIFO_DEPTH(2), .STARVE_MAX(4), .REG_NUM(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic applyStimulus(input logic a_we_n, input logic [4:0] a_addr, input logic [31:0] a_data,
                                input logic b_req, input logic [4:0] b_addr, input logic [31:0] b_data);
      bus.a_we_  = a_we_n;
      bus.a_addr = a_addr;
      bus.a_data = a_data;
      bus.b_req  = b_req;
      bus.b_addr = b_addr;
      bus.b_data = b_data;
   endtask

   task automatic checkPort(input string tag, input logic we_n, input logic [4:0] addr, input logic [31:0] data);
      checkOutput({tag, "_we"},   32'(bus.gpr_we_),     32'(we_n));
      checkOutput({tag, "_addr"}, 32'(bus.gpr_wr_addr), 32'(addr));
      checkOutput({tag, "_data"}, bus.gpr_wr_data,      data);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      applyStimulus(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      bus.sb_set      = 1'b0;
      bus.sb_set_addr = '0;
      bus.chk_addr_0  = '0;
      bus.chk_addr_1  = '0;
      bus.chk_addr_d  = '0;

      settle();
      checkPort("rst", 1'b1, 5'd0, 32'h0);
      checkOutput("rst_stall", 32'(bus.stall_req), 32'd0);
      checkOutput("rst_busy_d", 32'(bus.busy_d), 32'd0);
      checkOutput("rst_ack", 32'(bus.b_ack), 32'd0);
      tick();
      reset = 1'b1;
      tick();

      // Basic B write with scoreboard set and clear
      bus.sb_set = 1'b1; bus.sb_set_addr = 5'd5; bus.chk_addr_0 = 5'd5; bus.chk_addr_d = 5'd5;
      settle();
      checkOutput("b1_busy_pre", 32'(bus.busy_0), 32'd0);
      tick();
      bus.sb_set = 1'b0;
      applyStimulus(1'b1, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
      settle();
      checkOutput("b1_busy_set", 32'(bus.busy_0), 32'd1);
      checkOutput("b1_busy_d", 32'(bus.busy_d), 32'd1);
      checkOutput("b1_ack", 32'(bus.b_ack), 32'd1);
      checkOutput("b1_port_idle", 32'(bus.gpr_we_), 32'd1);
      tick();
      applyStimulus(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      settle();
      checkPort("b1_commit", 1'b0, 5'd5, 32'hDEADBEEF);
      checkOutput("b1_busy_hold", 32'(bus.busy_0), 32'd1);
      tick();
      settle();
      checkOutput("b1_busy_clr", 32'(bus.busy_0), 32'd0);
      checkPort("b1_after", 1'b1, 5'd0, 32'h0);

      // Starvation: A writes r1 every cycle while B fills the FIFO
      tick();
      applyStimulus(1'b0, 5'd1, 32'h100, 1'b1, 5'd9, 32'h99);
      settle();
      checkOutput("st_ack0", 32'(bus.b_ack), 32'd1);
      checkPort("st_a0", 1'b0, 5'd1, 32'h100);
      tick();
      applyStimulus(1'b0, 5'd1, 32'h101, 1'b1, 5'd10, 32'hAA);
      settle();
      checkOutput("st_ack1", 32'(bus.b_ack), 32'd1);
      checkPort("st_a1", 1'b0, 5'd1, 32'h101);
      tick();
      applyStimulus(1'b0, 5'd1, 32'h102, 1'b1, 5'd11, 32'hBB);
      settle();
      checkOutput("st_ack_full", 32'(bus.b_ack), 32'd0);
      checkOutput("st_stall2", 32'(bus.stall_req), 32'd0);
      tick();
      applyStimulus(1'b0, 5'd1, 32'h103, 1'b0, 5'd0, 32'h0);
      settle();
      checkOutput("st_stall3", 32'(bus.stall_req), 32'd0);
      tick();
      settle();
      checkOutput("st_stall4", 32'(bus.stall_req), 32'd0);
      tick();
      applyStimulus(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      settle();
      checkOutput("st_stall_on", 32'(bus.stall_req), 32'd1);
      checkPort("st_r9", 1'b0, 5'd9, 32'h99);
      tick();
      settle();
      checkOutput("st_stall_off", 32'(bus.stall_req), 32'd0);
      checkPort("st_r10", 1'b0, 5'd10, 32'hAA);
      tick();
      settle();
      checkPort("st_drained", 1'b1, 5'd0, 32'h0);

      // A wins over a pending head; head commits on the next idle cycle
      tick();
      applyStimulus(1'b1, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44);
      settle();
      checkOutput("pr_ack", 32'(bus.b_ack), 32'd1);
      tick();
      applyStimulus(1'b0, 5'd2, 32'h11, 1'b0, 5'd0, 32'h0);
      settle();
      checkPort("pr_a", 1'b0, 5'd2, 32'h11);
      tick();
      applyStimulus(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      settle();
      checkPort("pr_b", 1'b0, 5'd4, 32'h44);
      tick();
      settle();
      checkPort("pr_idle", 1'b1, 5'd0, 32'h0);

      // Full FIFO: a push on a pop cycle is still refused, accepted the cycle after
      tick();
      applyStimulus(1'b0, 5'd1, 32'h1, 1'b1, 5'd12, 32'h12);
      settle();
      checkOutput("fp_ack0", 32'(bus.b_ack), 32'd1);
      tick();
      applyStimulus(1'b0, 5'd1, 32'h2, 1'b1, 5'd13, 32'h13);
      settle();
      checkOutput("fp_ack1", 32'(bus.b_ack), 32'd1);
      tick();
      applyStimulus(1'b1, 5'd0, 32'h0, 1'b1, 5'd14, 32'h14);
      settle();
      checkOutput("fp_ack_pop", 32'(bus.b_ack), 32'd0);
      checkPort("fp_r12", 1'b0, 5'd12, 32'h12);
      tick();
      settle();
      checkOutput("fp_ack_retry", 32'(bus.b_ack), 32'd1);
      checkPort("fp_r13", 1'b0, 5'd13, 32'h13);
      tick();
      applyStimulus(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      settle();
      checkPort("fp_r14", 1'b0, 5'd14, 32'h14);
      tick();
      settle();
      checkPort("fp_idle", 1'b1, 5'd0, 32'h0);

      // Set and clear of r6 on the same edge leaves it busy
      tick();
      bus.sb_set = 1'b1; bus.sb_set_addr = 5'd6; bus.chk_addr_1 = 5'd6;
      tick();
      bus.sb_set = 1'b0;
      applyStimulus(1'b1, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66);
      settle();
      checkOutput("sc_busy_a", 32'(bus.busy_1), 32'd1);
      tick();
      applyStimulus(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      bus.sb_set = 1'b1; bus.sb_set_addr = 5'd6;
      settle();
      checkPort("sc_commit1", 1'b0, 5'd6, 32'h66);
      tick();
      bus.sb_set = 1'b0;
      applyStimulus(1'b1, 5'd0, 32'h0, 1'b1, 5'd6, 32'h67);
      settle();
      checkOutput("sc_busy_kept", 32'(bus.busy_1), 32'd1);
      tick();
      applyStimulus(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      settle();
      checkPort("sc_commit2", 1'b0, 5'd6, 32'h67);
      checkOutput("sc_busy_b", 32'(bus.busy_1), 32'd1);
      tick();
      settle();
      checkOutput("sc_busy_clr", 32'(bus.busy_1), 32'd0);

      // Reset in the middle of traffic: two entries queued, r3 and r7 busy
      tick();
      bus.chk_addr_0 = 5'd3; bus.chk_addr_1 = 5'd7;
      bus.sb_set = 1'b1; bus.sb_set_addr = 5'd3;
      applyStimulus(1'b0, 5'd1, 32'h5, 1'b1, 5'd20, 32'h20);
      tick();
      bus.sb_set_addr = 5'd7;
      applyStimulus(1'b0, 5'd1, 32'h6, 1'b1, 5'd21, 32'h21);
      tick();
      bus.sb_set = 1'b0;
      applyStimulus(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      settle();
      checkOutput("mr_busy3_pre", 32'(bus.busy_0), 32'd1);
      checkOutput("mr_busy7_pre", 32'(bus.busy_1), 32'd1);
      checkPort("mr_head_pre", 1'b0, 5'd20, 32'h20);
      reset = 1'b0;
      bus.b_req = 1'b1;
      #1;
      checkPort("mr_rst", 1'b1, 5'd0, 32'h0);
      checkOutput("mr_busy3", 32'(bus.busy_0), 32'd0);
      checkOutput("mr_busy7", 32'(bus.busy_1), 32'd0);
      checkOutput("mr_stall", 32'(bus.stall_req), 32'd0);
      checkOutput("mr_ack_req", 32'(bus.b_ack), 32'd1);
      bus.b_req = 1'b0;
      #1;
      checkOutput("mr_ack_noreq", 32'(bus.b_ack), 32'd0);
      tick();
      reset = 1'b1;
      tick();
      settle();
      checkPort("mr_after", 1'b1, 5'd0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
